// File: rtl/bsg_chip_reset_cord_sequencer.sv
// Per-client tag reset/cord join: holds every domain in reset for min_hold_p cycles, then releases
// clients one at a time in index order. Status outputs optional via BSG_CHIP_RESET_SEQ_STATUS_EN.
module bsg_chip_reset_cord_sequencer #(
  parameter int unsigned num_clients_p = 8,
  parameter int unsigned cord_width_p  = 7,
  parameter int unsigned min_hold_p    = 16,
  parameter int unsigned stagger_p     = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_clients_p-1:0]              new_i,
  input  logic [num_clients_p-1:0]              tag_reset_i,
  input  logic [num_clients_p*cord_width_p-1:0] tag_cord_i,
  output logic [num_clients_p-1:0]              reset_o,
  output logic                                  reset_any_o,
  output logic [num_clients_p*cord_width_p-1:0] cord_o
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
  ,
  output logic [1:0]                            state_o,
  output logic [15:0]                           reset_count_o
`endif
);

  localparam int unsigned HoldW = $clog2(min_hold_p + 1);
  localparam int unsigned StagW = (stagger_p > 1) ? $clog2(stagger_p) : 1;
  localparam int unsigned IdxW  = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;
  localparam int unsigned CordW = num_clients_p * cord_width_p;

  localparam logic [HoldW-1:0] HoldMax  = HoldW'(min_hold_p);
  localparam logic [StagW-1:0] StagLast = StagW'(stagger_p - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(num_clients_p - 1);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [StagW-1:0]         stag_cnt_q, stag_cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [num_clients_p-1:0] req_q, req_d;
  logic [num_clients_p-1:0] reset_q, reset_d;
  logic [CordW-1:0]         pend_cord_q, pend_cord_d;
  logic [CordW-1:0]         cord_q, cord_d;
  logic                     reset_trig;

  assign reset_trig = |(new_i & tag_reset_i);

  // Payload capture; every strobing client is latched in the same cycle.
  always_comb begin
    req_d       = req_q;
    pend_cord_d = pend_cord_q;
    for (int unsigned i = 0; i < num_clients_p; i++) begin
      if (new_i[i]) begin
        req_d[i]                                  = tag_reset_i[i];
        pend_cord_d[i*cord_width_p +: cord_width_p] = tag_cord_i[i*cord_width_p +: cord_width_p];
      end
    end
  end

  // A cord only moves while its domain is held in reset; a running domain keeps its cord.
  always_comb begin
    cord_d = cord_q;
    for (int unsigned i = 0; i < num_clients_p; i++) begin
      if (reset_q[i]) begin
        cord_d[i*cord_width_p +: cord_width_p] = pend_cord_q[i*cord_width_p +: cord_width_p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      idx_q       <= '0;
      req_q       <= '1;
      reset_q     <= '1;
      pend_cord_q <= '0;
      cord_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      idx_q       <= idx_d;
      req_q       <= req_d;
      reset_q     <= reset_d;
      pend_cord_q <= pend_cord_d;
      cord_q      <= cord_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    idx_d      = idx_q;
    reset_d    = reset_q;
    unique case (state_q)
      StHold: begin
        reset_d    = '1;
        stag_cnt_d = '0;
        idx_d      = '0;
        if (reset_trig) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
        if (!reset_trig && (hold_cnt_q == HoldMax) && (req_q == '0)) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (reset_trig) begin
          state_d    = StHold;
          reset_d    = '1;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          idx_d      = '0;
        end else if (stag_cnt_q == StagLast) begin
          reset_d[idx_q] = 1'b0;
          stag_cnt_d     = '0;
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          stag_cnt_d = stag_cnt_q + StagW'(1);
        end
      end
      StRun: begin
        if (reset_trig) begin
          state_d    = StHold;
          reset_d    = '1;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          idx_d      = '0;
        end
      end
      default: begin
        state_d    = StHold;
        reset_d    = '1;
        hold_cnt_d = '0;
      end
    endcase
  end

`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
  logic [15:0] reset_count_q, reset_count_d;

  // Counts re-entries into hold from release or run, saturating.
  always_comb begin
    reset_count_d = reset_count_q;
    if ((state_q != StHold) && (state_d == StHold) && (reset_count_q != 16'hFFFF)) begin
      reset_count_d = reset_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reset_count_q <= '0;
    end else begin
      reset_count_q <= reset_count_d;
    end
  end
`endif

  always_comb begin
    reset_o     = reset_q;
    reset_any_o = |reset_q;
    cord_o      = cord_q;
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
    state_o       = state_q;
    reset_count_o = reset_count_q;
`endif
  end

endmodule

// File: tb/tb_bsg_chip_reset_cord_sequencer.sv
// Scoreboard bench for bsg_chip_reset_cord_sequencer: expected per-cycle reset_o values are queued
// from the release timeline and popped as the DUT reaches each cycle.
module tb_bsg_chip_reset_cord_sequencer;

  localparam int N    = 8;
  localparam int CW   = 7;
  localparam int Stag = 4;
  localparam int Far  = -100000;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b0;
  logic [N-1:0]    new_i = '0;
  logic [N-1:0]    tag_reset_i = '0;
  logic [N*CW-1:0] tag_cord_i = '0;
  logic [N-1:0]    reset_o;
  logic            reset_any_o;
  logic [N*CW-1:0] cord_o;
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
  logic [1:0]      state_o;
  logic [15:0]     reset_count_o;
`endif

  typedef struct {
    int           cyc;
    logic [N-1:0] rst;
  } exp_t;

  exp_t            sb[$];
  logic [N*CW-1:0] exp_cord;
  int              cyc;
  int              n_checks;
  int              n_fail;

  always #5 clk_i = ~clk_i;

  bsg_chip_reset_cord_sequencer #(
    .num_clients_p(N),
    .cord_width_p (CW),
    .min_hold_p   (16),
    .stagger_p    (Stag)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .new_i        (new_i),
    .tag_reset_i  (tag_reset_i),
    .tag_cord_i   (tag_cord_i),
    .reset_o      (reset_o),
    .reset_any_o  (reset_any_o),
    .cord_o       (cord_o)
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
    ,
    .state_o      (state_o),
    .reset_count_o(reset_count_o)
`endif
  );

  // Expected reset_o d cycles after release entry: one client drops every Stag cycles.
  function automatic logic [N-1:0] pat(input int d);
    logic [N-1:0] ones;
    int n;
    ones = '1;
    if (d < 0) return ones;
    n = d / Stag;
    if (n > N) n = N;
    return ones << n;
  endfunction

  task automatic push_range(input int from, input int to, input int entry);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc = c;
      e.rst = pat(c - entry);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) tag_cord_i[i*CW +: CW] = CW'(i);
    exp_cord = tag_cord_i;
    #2 reset_i = 1'b1;
    #1;
    n_checks++;
    if (reset_o !== 8'hFF || reset_any_o !== 1'b1 || cord_o !== '0) begin
      n_fail++;
      $display("FAIL reset_async: reset_o=%h any=%b cord=%h, expected FF 1 0",
               reset_o, reset_any_o, cord_o);
    end
    tick();
    tick();
    n_checks++;
    if (reset_o !== 8'hFF || reset_any_o !== 1'b1 || cord_o !== '0) begin
      n_fail++;
      $display("FAIL reset_held: reset_o=%h any=%b cord=%h, expected FF 1 0",
               reset_o, reset_any_o, cord_o);
    end
  endtask

  task automatic test_release();
    exp_t e;
    reset_i = 1'b0;
    cyc = 0;
    push_range(1, 50, 17);
    while (cyc < 50) begin
      new_i = '0;
      tag_reset_i = '0;
      if (cyc == 1) new_i = '1;
      tick();
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
      if (cyc == 16 || cyc == 17 || cyc == 49) begin
        n_checks++;
        if (state_o !== ((cyc == 16) ? 2'd0 : (cyc == 17) ? 2'd1 : 2'd2)) begin
          n_fail++;
          $display("FAIL release_state cyc %0d: state_o=%0d", cyc, state_o);
        end
      end
`endif
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (reset_o !== e.rst || reset_any_o !== (|e.rst)) begin
          n_fail++;
          $display("FAIL release cyc %0d: reset_o=%h any=%b, expected %h any=%b",
                   cyc, reset_o, reset_any_o, e.rst, |e.rst);
        end
      end
    end
    n_checks++;
    if (cord_o !== exp_cord) begin
      n_fail++;
      $display("FAIL release_cords: cord_o=%h, expected %h", cord_o, exp_cord);
    end
  endtask

  task automatic test_trigger_run();
    exp_t e;
    int s, t, c, ent, fin;
    s = cyc; t = s + 2; c = t + 20; ent = c + 1; fin = ent + 34;
    push_range(s + 1, t - 1, Far);
    push_range(t, fin, ent);
    while (cyc < fin) begin
      new_i = '0;
      tag_reset_i = '0;
      if (cyc == t - 1) begin new_i[3] = 1'b1; tag_reset_i[3] = 1'b1; end
      if (cyc == c - 1) new_i[3] = 1'b1;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (reset_o !== e.rst || reset_any_o !== (|e.rst)) begin
          n_fail++;
          $display("FAIL trigger_run cyc %0d: reset_o=%h any=%b, expected %h any=%b",
                   cyc, reset_o, reset_any_o, e.rst, |e.rst);
        end
      end
    end
  endtask

  task automatic test_abort_release();
    exp_t e;
    int s, t, ent, a, ent2, fin;
    s = cyc; t = s + 2; ent = t + 17; a = ent + 13; ent2 = a + 17; fin = ent2 + 34;
    push_range(s + 1, t - 1, Far);
    push_range(t, a - 1, ent);
    push_range(a, fin, ent2);
    while (cyc < fin) begin
      new_i = '0;
      tag_reset_i = '0;
      if (cyc == t - 1) begin new_i[0] = 1'b1; tag_reset_i[0] = 1'b1; end
      if (cyc == t) new_i[0] = 1'b1;
      if (cyc == a - 1) begin new_i[5] = 1'b1; tag_reset_i[5] = 1'b1; end
      if (cyc == a) new_i[5] = 1'b1;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (reset_o !== e.rst || reset_any_o !== (|e.rst)) begin
          n_fail++;
          $display("FAIL abort_release cyc %0d: reset_o=%h any=%b, expected %h any=%b",
                   cyc, reset_o, reset_any_o, e.rst, |e.rst);
        end
      end
    end
  endtask

  task automatic test_cord_run();
    exp_t e;
    int s, w, t, ent, fin;
    s = cyc; w = s + 2; t = s + 6; ent = t + 17; fin = ent + 34;
    push_range(s + 1, t - 1, Far);
    push_range(t, fin, ent);
    while (cyc < fin) begin
      new_i = '0;
      tag_reset_i = '0;
      if (cyc == w - 1) begin
        tag_cord_i[4*CW +: CW] = 7'h2A;
        new_i[4] = 1'b1;
      end
      if (cyc == t - 1) begin new_i[0] = 1'b1; tag_reset_i[0] = 1'b1; end
      if (cyc == t) new_i[0] = 1'b1;
      tick();
      if (cyc == t - 1 || cyc == t || cyc == t + 1) begin
        n_checks++;
        if (cord_o[4*CW +: CW] !== ((cyc == t + 1) ? 7'h2A : 7'h04)) begin
          n_fail++;
          $display("FAIL cord_run cyc %0d: cord_o[4]=%h, expected %h", cyc,
                   cord_o[4*CW +: CW], (cyc == t + 1) ? 7'h2A : 7'h04);
        end
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (reset_o !== e.rst || reset_any_o !== (|e.rst)) begin
          n_fail++;
          $display("FAIL cord_run_rst cyc %0d: reset_o=%h any=%b, expected %h any=%b",
                   cyc, reset_o, reset_any_o, e.rst, |e.rst);
        end
      end
    end
    exp_cord[4*CW +: CW] = 7'h2A;
    n_checks++;
    if (cord_o !== exp_cord) begin
      n_fail++;
      $display("FAIL cord_run_final: cord_o=%h, expected %h", cord_o, exp_cord);
    end
  endtask

  task automatic test_hold_retrigger();
    exp_t e;
    int s, t, r, ent, fin;
    s = cyc; t = s + 2; r = t + 11; ent = r + 17; fin = ent + 34;
    push_range(s + 1, t - 1, Far);
    push_range(t, fin, ent);
    while (cyc < fin) begin
      new_i = '0;
      tag_reset_i = '0;
      if (cyc == t - 1) begin new_i[1] = 1'b1; tag_reset_i[1] = 1'b1; end
      if (cyc == t) new_i[1] = 1'b1;
      if (cyc == r - 1) begin new_i[2] = 1'b1; tag_reset_i[2] = 1'b1; end
      if (cyc == r) new_i[2] = 1'b1;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (reset_o !== e.rst || reset_any_o !== (|e.rst)) begin
          n_fail++;
          $display("FAIL hold_retrigger cyc %0d: reset_o=%h any=%b, expected %h any=%b",
                   cyc, reset_o, reset_any_o, e.rst, |e.rst);
        end
      end
    end
  endtask

  task automatic test_async_reset();
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
    n_checks++;
    if (reset_count_o !== 16'd5 || state_o !== 2'd2) begin
      n_fail++;
      $display("FAIL status_run: reset_count_o=%0d state_o=%0d, expected 5 2",
               reset_count_o, state_o);
    end
`endif
    #3 reset_i = 1'b1;
    #1;
    n_checks++;
    if (reset_o !== 8'hFF || reset_any_o !== 1'b1 || cord_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: reset_o=%h any=%b cord=%h, expected FF 1 0",
               reset_o, reset_any_o, cord_o);
    end
`ifdef BSG_CHIP_RESET_SEQ_STATUS_EN
    n_checks++;
    if (reset_count_o !== 16'd0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL async_status: reset_count_o=%0d state_o=%0d, expected 0 0",
               reset_count_o, state_o);
    end
`endif
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_release();
    test_trigger_run();
    test_abort_release();
    test_cord_run();
    test_hold_retrigger();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
